// File: rtl/sin_tone_pkg.sv
// Shared types and constants for the two-channel sine tone generator.
package sin_tone_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOOK1 = 3'd1,
    ST_LOOK2 = 3'd2,
    ST_MIX   = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  localparam int LUT_DEPTH    = 64;
  localparam int SAMPLE_W_DEF = 16;
  localparam int GAIN_FULL    = 16;

endpackage

// File: rtl/sin_lut_64.sv
// 64-entry full-period sine ROM, round(32767*sin(2*pi*k/64)), one-cycle read latency.
module sin_lut_64
  import sin_tone_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       clk_i,
  input  logic [5:0]                 addr_i,
  output logic signed [SAMPLE_W-1:0] data_o
);

  // First quadrant magnitudes, indices 0..16; the rest follows by symmetry.
  function automatic logic [15:0] quarter(input logic [4:0] idx);
    case (idx)
      5'd0:    return 16'd0;
      5'd1:    return 16'd3212;
      5'd2:    return 16'd6393;
      5'd3:    return 16'd9512;
      5'd4:    return 16'd12539;
      5'd5:    return 16'd15446;
      5'd6:    return 16'd18204;
      5'd7:    return 16'd20787;
      5'd8:    return 16'd23170;
      5'd9:    return 16'd25329;
      5'd10:   return 16'd27245;
      5'd11:   return 16'd28898;
      5'd12:   return 16'd30273;
      5'd13:   return 16'd31356;
      5'd14:   return 16'd32137;
      5'd15:   return 16'd32609;
      default: return 16'd32767;
    endcase
  endfunction

  logic [4:0]                 q_idx;
  logic signed [SAMPLE_W-1:0] mag;

  always_comb begin
    q_idx = addr_i[4] ? (5'd16 - {1'b0, addr_i[3:0]}) : {1'b0, addr_i[3:0]};
    mag   = SAMPLE_W'(quarter(q_idx));
  end

  always_ff @(posedge clk_i) begin
    data_o <= addr_i[5] ? -mag : mag;
  end

endmodule

// File: rtl/sin_clk_tone_gen.sv
// Two-channel phase-accumulator tone generator with shared sine ROM and mixed output.
// Define SIN_TONE_FADE_EN for per-channel fading gain instead of hard mute.
module sin_clk_tone_gen
  import sin_tone_pkg::*;
#(
  parameter int PHASE_W  = 16,
  parameter int LUT_AW   = 6,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iSin_CLK,
  input  logic                       isound_off1,
  input  logic                       isound_off2,
  input  logic [PHASE_W-1:0]         iTone1_inc,
  input  logic [PHASE_W-1:0]         iTone2_inc,
  input  logic                       iSample_ready,
  input  logic                       iOvr_clr,
  output logic signed [SAMPLE_W-1:0] oSample,
  output logic                       oSample_valid,
  output logic                       oOverrun,
  output state_e                     oFsm_state
);

  // Handshake: a sample transfers on a rising edge where oSample_valid and
  // iSample_ready are both high; until then oSample/oSample_valid hold steady.

  logic                       sync1_q, sync2_q, edge_q, tick;
  state_e                     state_q, state_d;
  logic [PHASE_W-1:0]         phase1_q, phase1_d, phase2_q, phase2_d;
  logic                       mute1_q, mute1_d, mute2_q, mute2_d;
  logic signed [SAMPLE_W-1:0] s1_q, s1_d, sample_q, sample_d;
  logic signed [SAMPLE_W-1:0] term1, term2, lut_data;
  logic                       valid_q, valid_d, ovr_q, ovr_d;
  logic [LUT_AW-1:0]          lut_addr;

`ifdef SIN_TONE_FADE_EN
  localparam int PW = SAMPLE_W + 6;
  logic [4:0]          gain1_q, gain1_d, gain2_q, gain2_d;
  logic signed [PW-1:0] prod1, prod2;
`endif

  assign tick     = sync2_q & ~edge_q;
  assign lut_addr = (state_q == ST_LOOK2) ? phase2_q[PHASE_W-1 -: LUT_AW]
                                          : phase1_q[PHASE_W-1 -: LUT_AW];

  sin_lut_64 #(.SAMPLE_W(SAMPLE_W)) u_lut (
    .clk_i  (iCLK),
    .addr_i (lut_addr),
    .data_o (lut_data)
  );

  // Channel 2 is read straight off the ROM during MIX; channel 1 was captured in LOOK2.
  always_comb begin
    term1 = '0;
    term2 = '0;
`ifdef SIN_TONE_FADE_EN
    prod1 = PW'(s1_q) * PW'($signed({1'b0, gain1_q}));
    prod2 = PW'(lut_data) * PW'($signed({1'b0, gain2_q}));
    term1 = SAMPLE_W'(prod1 >>> 5);
    term2 = SAMPLE_W'(prod2 >>> 5);
`else
    if (!mute1_q) term1 = s1_q >>> 1;
    if (!mute2_q) term2 = lut_data >>> 1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    phase1_d = phase1_q;
    phase2_d = phase2_q;
    mute1_d  = mute1_q;
    mute2_d  = mute2_q;
    s1_d     = s1_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_d    = iOvr_clr ? 1'b0 : ovr_q;
`ifdef SIN_TONE_FADE_EN
    gain1_d  = gain1_q;
    gain2_d  = gain2_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          phase1_d = phase1_q + iTone1_inc;
          phase2_d = phase2_q + iTone2_inc;
          mute1_d  = isound_off1;
          mute2_d  = isound_off2;
          state_d  = ST_LOOK1;
        end
      end
      ST_LOOK1: begin
`ifdef SIN_TONE_FADE_EN
        // Gains step once per accepted tick, ready before MIX uses them.
        if (mute1_q) gain1_d = (gain1_q == 5'd0) ? 5'd0 : gain1_q - 5'd1;
        else         gain1_d = (gain1_q >= 5'(GAIN_FULL)) ? 5'(GAIN_FULL) : gain1_q + 5'd1;
        if (mute2_q) gain2_d = (gain2_q == 5'd0) ? 5'd0 : gain2_q - 5'd1;
        else         gain2_d = (gain2_q >= 5'(GAIN_FULL)) ? 5'(GAIN_FULL) : gain2_q + 5'd1;
`endif
        state_d = ST_LOOK2;
      end
      ST_LOOK2: begin
        s1_d    = lut_data;
        state_d = ST_MIX;
      end
      ST_MIX: begin
        sample_d = term1 + term2;
        valid_d  = 1'b1;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (iSample_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A tick that arrives while busy is dropped; setting beats clearing.
    if (tick && (state_q != ST_IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      edge_q   <= 1'b0;
      state_q  <= ST_IDLE;
      phase1_q <= '0;
      phase2_q <= '0;
      mute1_q  <= 1'b0;
      mute2_q  <= 1'b0;
      s1_q     <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef SIN_TONE_FADE_EN
      gain1_q  <= 5'(GAIN_FULL);
      gain2_q  <= 5'(GAIN_FULL);
`endif
    end else begin
      sync1_q  <= iSin_CLK;
      sync2_q  <= sync1_q;
      edge_q   <= sync2_q;
      state_q  <= state_d;
      phase1_q <= phase1_d;
      phase2_q <= phase2_d;
      mute1_q  <= mute1_d;
      mute2_q  <= mute2_d;
      s1_q     <= s1_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
`ifdef SIN_TONE_FADE_EN
      gain1_q  <= gain1_d;
      gain2_q  <= gain2_d;
`endif
    end
  end

  assign oSample       = sample_q;
  assign oSample_valid = valid_q;
  assign oOverrun      = ovr_q;
  assign oFsm_state    = state_q;

endmodule

// File: tb/tb_sin_clk_tone_gen.sv
// Randomized and directed bench for sin_clk_tone_gen against a sine/phase reference model.
`timescale 1ns/1ps
module tb_sin_clk_tone_gen;
  import sin_tone_pkg::*;

  localparam int PHASE_W  = 16;
  localparam int SAMPLE_W = 16;

  logic                       iCLK = 1'b0;
  logic                       iRST = 1'b1;
  logic                       iSin_CLK = 1'b0;
  logic                       isound_off1 = 1'b0, isound_off2 = 1'b0;
  logic [PHASE_W-1:0]         iTone1_inc = '0, iTone2_inc = '0;
  logic                       iSample_ready = 1'b0, iOvr_clr = 1'b0;
  logic signed [SAMPLE_W-1:0] oSample;
  logic                       oSample_valid, oOverrun;
  state_e                     oFsm_state;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [SAMPLE_W-1:0] exp_q[$];
  logic [SAMPLE_W-1:0] mon_exp;
  logic [SAMPLE_W-1:0] last_exp;
  int sine_ref[64];
  int ph1 = 0, ph2 = 0;
`ifdef SIN_TONE_FADE_EN
  int g1 = 16, g2 = 16;
`endif

  // ---------------- clock / reset ----------------
  always #5 iCLK = ~iCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  sin_clk_tone_gen dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iSin_CLK      (iSin_CLK),
    .isound_off1   (isound_off1),
    .isound_off2   (isound_off2),
    .iTone1_inc    (iTone1_inc),
    .iTone2_inc    (iTone2_inc),
    .iSample_ready (iSample_ready),
    .iOvr_clr      (iOvr_clr),
    .oSample       (oSample),
    .oSample_valid (oSample_valid),
    .oOverrun      (oOverrun),
    .oFsm_state    (oFsm_state)
  );

  task automatic check_eq(input string tag, input logic signed [31:0] act,
                          input logic signed [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic build_sine();
    real r;
    for (int k = 0; k < 64; k++) begin
      r = 32767.0 * $sin(2.0 * 3.14159265358979 * k / 64.0);
      sine_ref[k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    end
  endtask

  task automatic model_tick(input int inc1, input int inc2, input bit m1, input bit m2);
    int s1, s2, t1, t2;
    ph1 = (ph1 + inc1) % 65536;
    ph2 = (ph2 + inc2) % 65536;
    s1  = sine_ref[ph1 / 1024];
    s2  = sine_ref[ph2 / 1024];
`ifdef SIN_TONE_FADE_EN
    g1 = m1 ? ((g1 > 0) ? g1 - 1 : 0) : ((g1 < 16) ? g1 + 1 : 16);
    g2 = m2 ? ((g2 > 0) ? g2 - 1 : 0) : ((g2 < 16) ? g2 + 1 : 16);
    t1 = (s1 * g1) >>> 5;
    t2 = (s2 * g2) >>> 5;
`else
    t1 = m1 ? 0 : (s1 >>> 1);
    t2 = m2 ? 0 : (s2 >>> 1);
`endif
    last_exp = SAMPLE_W'(t1 + t2);
    exp_q.push_back(last_exp);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge iCLK) begin
    #1;
    if (!iRST && oSample_valid && iSample_ready) begin
      check_eq("sample_expected_avail", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check_eq("sample_value", oSample, $signed(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(negedge iCLK);
    iRST = 1'b1;
    iSin_CLK = 1'b0;
    exp_q.delete();
    ph1 = 0;
    ph2 = 0;
`ifdef SIN_TONE_FADE_EN
    g1 = 16;
    g2 = 16;
`endif
    repeat (n) @(negedge iCLK);
    iRST = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!oSample_valid && n < 20) begin
      @(negedge iCLK);
      n++;
    end
    check_eq({tag, "_valid_seen"}, oSample_valid, 1);
  endtask

  task automatic start_tick(input int inc1, input int inc2, input bit m1, input bit m2);
    @(negedge iCLK);
    iTone1_inc  = PHASE_W'(inc1);
    iTone2_inc  = PHASE_W'(inc2);
    isound_off1 = m1;
    isound_off2 = m2;
    model_tick(inc1, inc2, m1, m2);
    iSin_CLK = 1'b1;
  endtask

  task automatic drop_pulse();
    iSin_CLK = 1'b1;
    repeat (3) @(negedge iCLK);
    iSin_CLK = 1'b0;
    repeat (3) @(negedge iCLK);
  endtask

  task automatic txn(input int inc1, input int inc2, input bit m1, input bit m2,
                     input int delay);
    iSample_ready = 1'b0;
    start_tick(inc1, inc2, m1, m2);
    wait_valid("txn");
    repeat (delay) @(negedge iCLK);
    iSample_ready = 1'b1;
    @(negedge iCLK);
    check_eq("valid_cleared", oSample_valid, 0);
    iSample_ready = 1'b0;
    iSin_CLK = 1'b0;
    repeat (3) @(negedge iCLK);
    check_eq("fsm_idle", oFsm_state, ST_IDLE);
  endtask

  task automatic directed_first(input string tag);
    iSample_ready = 1'b1;
    start_tick(16'h0400, 0, 1'b0, 1'b0);
    repeat (5) @(negedge iCLK);
    check_eq({tag, "_not_yet_valid"}, oSample_valid, 0);
    @(negedge iCLK);
    check_eq({tag, "_valid_at_4"}, oSample_valid, 1);
    check_eq({tag, "_sample"}, oSample, 32'sh0646);
    @(negedge iCLK);
    check_eq({tag, "_valid_one_cycle"}, oSample_valid, 0);
    iSample_ready = 1'b0;
    iSin_CLK = 1'b0;
    repeat (3) @(negedge iCLK);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    build_sine();
    do_reset(3);
    check_eq("rst_sample", oSample, 0);
    check_eq("rst_valid", oSample_valid, 0);
    check_eq("rst_overrun", oOverrun, 0);
    check_eq("rst_state", oFsm_state, ST_IDLE);

    directed_first("first");

    // Held sample while ticks are dropped, then clear and set/clear collision.
    start_tick(int'($urandom_range(65535)), int'($urandom_range(65535)), 1'b0, 1'b0);
    wait_valid("hold");
    iSin_CLK = 1'b0;
    repeat (3) @(negedge iCLK);
    drop_pulse();
    drop_pulse();
    repeat (22) @(negedge iCLK);
    check_eq("hold_sample_stable", oSample, $signed(last_exp));
    check_eq("hold_valid", oSample_valid, 1);
    check_eq("hold_overrun", oOverrun, 1);
    iOvr_clr = 1'b1;
    @(negedge iCLK);
    iOvr_clr = 1'b0;
    check_eq("ovr_cleared", oOverrun, 0);

    iSin_CLK = 1'b1;
    repeat (2) @(negedge iCLK);
    iOvr_clr = 1'b1;
    @(negedge iCLK);
    iOvr_clr = 1'b0;
    check_eq("ovr_set_wins", oOverrun, 1);
    iSin_CLK = 1'b0;
    repeat (3) @(negedge iCLK);
    iOvr_clr = 1'b1;
    @(negedge iCLK);
    iOvr_clr = 1'b0;
    check_eq("ovr_cleared2", oOverrun, 0);

    iSin_CLK = 1'b1;
    repeat (2) @(negedge iCLK);
    iSample_ready = 1'b1;
    @(negedge iCLK);
    iSample_ready = 1'b0;
    check_eq("accept_tick_valid", oSample_valid, 0);
    check_eq("accept_tick_overrun", oOverrun, 1);
    iSin_CLK = 1'b0;
    repeat (3) @(negedge iCLK);
    check_eq("accept_tick_idle", oFsm_state, ST_IDLE);

    // Reset in the middle of HOLD discards the sample and overrun.
    start_tick(int'($urandom_range(65535)), int'($urandom_range(65535)), 1'b0, 1'b0);
    wait_valid("midhold");
    iSin_CLK = 1'b0;
    repeat (3) @(negedge iCLK);
    drop_pulse();
    check_eq("midhold_overrun", oOverrun, 1);
    do_reset(2);
    check_eq("midhold_rst_sample", oSample, 0);
    check_eq("midhold_rst_valid", oSample_valid, 0);
    check_eq("midhold_rst_overrun", oOverrun, 0);
    repeat (3) @(negedge iCLK);
    check_eq("midhold_rst_quiet", oSample_valid, 0);
    directed_first("after_rst");

    // Both channels muted.
    txn(int'($urandom_range(65535)), int'($urandom_range(65535)), 1'b1, 1'b1, 1);
`ifndef SIN_TONE_FADE_EN
    check_eq("mute_both_zero", oSample, 0);
`else
    check_eq("mute_fade_term", oSample, $signed(last_exp));
`endif

    // Phase wrap: 64 steps of 0x0400 bring channel 1 back to index 0.
    do_reset(2);
    for (int i = 0; i < 64; i++) txn(16'h0400, 0, 1'b0, 1'b0, 0);
    repeat (4) @(negedge iCLK);
    check_eq("wrap_term_zero", oSample, 0);

    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      txn(int'($urandom_range(65535)), int'($urandom_range(65535)),
          ($urandom_range(3) == 0), ($urandom_range(3) == 0),
          int'($urandom_range(5)));
      check_eq("rand_retained", oSample, $signed(last_exp));
    end

    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("final_overrun", oOverrun, 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
